// File: rtl/vxe_intr_pkg.sv
// ============================================================================
// Module   : vxe_intr_pkg
// Purpose  : Shared FSM state encodings and sizing helper for the VxEngine
//            second-generation interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vxe_intr_pkg;

  // Deferral FSM state encodings (legacy-compatible 2-bit values)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Width of the source index; at least one bit even for a single source
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : vxe_intr_pkg

`default_nettype wire

// File: rtl/vxe_intr_coal.sv
// ============================================================================
// Module   : vxe_intr_coal
// Purpose  : One interrupt-source coalescing slice. Counts events, runs an
//            age timer from the first buffered event and fires on either
//            reaching the count threshold or hitting the timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vxe_intr_coal #(
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev_i,
  input  logic [CNT_W-1:0] thr_i,
  input  logic [TMO_W-1:0] tmo_i,
  output logic             fire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmr_q, tmr_d;
  logic [CNT_W:0]   sum_w;
  logic [CNT_W:0]   thr_eff_w;
  logic             fire_thr_w;
  logic             fire_tmo_w;

  // Fire decision: threshold compared one bit wider so a saturated count
  // plus the incoming event cannot wrap below the threshold.
  always_comb begin
    thr_eff_w  = (thr_i == '0) ? (CNT_W+1)'(1) : {1'b0, thr_i};
    sum_w      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, ev_i};
    fire_thr_w = (sum_w >= thr_eff_w);
    fire_tmo_w = (tmo_i != '0) && (cnt_q != '0) &&
                 (tmr_q == (tmo_i - TMO_W'(1)));
    fire_o     = fire_thr_w | fire_tmo_w;
  end

  // Next count/age: clear on fire, otherwise saturating accumulate; the age
  // timer starts at zero on the first event and runs while events are held.
  always_comb begin
    cnt_d = cnt_q;
    tmr_d = tmr_q;
    if (fire_o) begin
      cnt_d = '0;
      tmr_d = '0;
    end else begin
      if (ev_i && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_q == '0) begin
        if (ev_i) begin
          tmr_d = '0;
        end
      end else if (tmr_q != '1) begin
        tmr_d = tmr_q + TMO_W'(1);
      end
    end
  end

  // Counter and timer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tmr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
    end
  end

endmodule : vxe_intr_coal

`default_nettype wire

// File: rtl/vxe_intr_ctrl.sv
// ============================================================================
// Module   : vxe_intr_ctrl
// Purpose  : VxEngine interrupt controller. Defers CU events while the CU is
//            busy, coalesces events per source, holds W1C raw status and
//            drives the interrupt line plus a priority-encoded source index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vxe_intr_ctrl
  import vxe_intr_pkg::*;
#(
  parameter int NR_INT = 8,
  parameter int CNT_W  = 8,
  parameter int TMO_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_cu_busy,
  input  logic [NR_INT-1:0]               i_cu_intr,
  input  logic [NR_INT-1:0]               i_rio_mask,
  input  logic                            i_rio_ack_en,
  input  logic [NR_INT-1:0]               i_rio_ack,
  input  logic [CNT_W-1:0]                i_rio_coal_thr,
  input  logic [TMO_W-1:0]                i_rio_coal_tmo,
  output logic [NR_INT-1:0]               o_rio_raw,
  output logic [NR_INT-1:0]               o_rio_active,
  output logic [NR_INT-1:0]               o_rio_pend,
  output logic [id_width(NR_INT)-1:0]     o_rio_id,
  output logic                            o_rio_id_vld,
  output logic                            o_intr
);

  localparam int ID_W = id_width(NR_INT);

  logic [1:0]        state_q, state_d;
  logic [NR_INT-1:0] pend_q, pend_d;
  logic [NR_INT-1:0] raw_q, raw_d;
  logic [NR_INT-1:0] feed_w;
  logic [NR_INT-1:0] fire_w;
  logic [NR_INT-1:0] ack_clr_w;
  logic [NR_INT-1:0] active_w;
  logic [ID_W-1:0]   id_w;

  // Deferral FSM: route events to the coalescers or into the pend buffer
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    feed_w  = '0;
    case (state_q)
      ST_IDLE: begin
        feed_w = i_cu_intr;
        if (i_cu_busy) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        pend_d = pend_q | i_cu_intr;
        if (!i_cu_busy) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        feed_w  = pend_q | i_cu_intr;
        pend_d  = '0;
        state_d = i_cu_busy ? ST_BUSY : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One coalescing slice per source
  generate
    for (genvar g = 0; g < NR_INT; g++) begin : g_coal
      vxe_intr_coal #(
        .CNT_W (CNT_W),
        .TMO_W (TMO_W)
      ) u_coal (
        .clk    (clk),
        .rst    (rst),
        .ev_i   (feed_w[g]),
        .thr_i  (i_rio_coal_thr),
        .tmo_i  (i_rio_coal_tmo),
        .fire_o (fire_w[g])
      );
    end
  endgenerate

  // Raw status update: ack clears, a simultaneous fire on the same bit wins
  always_comb begin
    ack_clr_w = i_rio_ack_en ? i_rio_ack : '0;
    raw_d     = (raw_q & ~ack_clr_w) | fire_w;
  end

  // FSM, deferral buffer and raw status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      raw_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      raw_q   <= raw_d;
    end
  end

  // Lowest-index priority encoder over unmasked raw bits
  always_comb begin
    active_w = raw_q & ~i_rio_mask;
    id_w     = '0;
    for (int i = NR_INT - 1; i >= 0; i--) begin
      if (active_w[i]) id_w = ID_W'(i);
    end
  end

  assign o_rio_raw    = raw_q;
  assign o_rio_active = active_w;
  assign o_rio_pend   = pend_q;
  assign o_rio_id     = id_w;
  assign o_rio_id_vld = |active_w;
  assign o_intr       = |active_w;

endmodule : vxe_intr_ctrl

`default_nettype wire

// File: tb/tb_vxe_intr_ctrl.sv
// ============================================================================
// Module   : tb_vxe_intr_ctrl
// Purpose  : Self-checking bench for vxe_intr_ctrl. A driver issues directed
//            and random stimulus and pushes the reference model's expected
//            outputs into a queue; a monitor pops and compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vxe_intr_ctrl;

  localparam int NR_INT = 8;
  localparam int CNT_W  = 8;
  localparam int TMO_W  = 16;
  localparam int ID_W   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              busy;
  logic [NR_INT-1:0] intr;
  logic [NR_INT-1:0] mask;
  logic              ack_en;
  logic [NR_INT-1:0] ack;
  logic [CNT_W-1:0]  thr;
  logic [TMO_W-1:0]  tmo;
  logic [NR_INT-1:0] raw, active, pend;
  logic [ID_W-1:0]   id;
  logic              id_vld, irq;

  always #5 clk = ~clk;

  vxe_intr_ctrl #(.NR_INT(NR_INT), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_cu_busy      (busy),
    .i_cu_intr      (intr),
    .i_rio_mask     (mask),
    .i_rio_ack_en   (ack_en),
    .i_rio_ack      (ack),
    .i_rio_coal_thr (thr),
    .i_rio_coal_tmo (tmo),
    .o_rio_raw      (raw),
    .o_rio_active   (active),
    .o_rio_pend     (pend),
    .o_rio_id       (id),
    .o_rio_id_vld   (id_vld),
    .o_intr         (irq)
  );

  typedef struct packed {
    logic [NR_INT-1:0] raw;
    logic [NR_INT-1:0] pend;
    logic [NR_INT-1:0] active;
    logic [ID_W-1:0]   id;
    logic              vld;
    logic              irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: per-source event counts and ages, deferred-event set,
  // and the CU busy level seen one and two cycles ago.
  int              m_cnt[NR_INT];
  int              m_age[NR_INT];
  bit [NR_INT-1:0] m_raw;
  bit [NR_INT-1:0] m_def;
  bit              m_b1, m_b2;

  function automatic void m_reset();
    for (int i = 0; i < NR_INT; i++) begin
      m_cnt[i] = 0;
      m_age[i] = 0;
    end
    m_raw = '0;
    m_def = '0;
    m_b1  = 1'b0;
    m_b2  = 1'b0;
  endfunction

  // Events are held back while the CU was busy last cycle, and released
  // together on the first cycle after it went idle.
  function automatic void m_step(bit b, bit [NR_INT-1:0] ev_in, bit a_en,
                                 bit [NR_INT-1:0] a_bits, int t, int to);
    bit [NR_INT-1:0] fed;
    bit [NR_INT-1:0] fires;
    int              t_eff;
    int              ev;
    fed   = '0;
    fires = '0;
    t_eff = (t == 0) ? 1 : t;
    if (m_b1) begin
      m_def = m_def | ev_in;
    end else if (m_b2) begin
      fed   = m_def | ev_in;
      m_def = '0;
    end else begin
      fed = ev_in;
    end
    for (int i = 0; i < NR_INT; i++) begin
      ev = fed[i] ? 1 : 0;
      if ((m_cnt[i] + ev >= t_eff) ||
          (to != 0 && m_cnt[i] != 0 && m_age[i] == to - 1)) begin
        fires[i] = 1'b1;
        m_cnt[i] = 0;
        m_age[i] = 0;
      end else begin
        if (m_cnt[i] == 0) begin
          if (ev != 0) m_age[i] = 0;
        end else if (m_age[i] < 65535) begin
          m_age[i] = m_age[i] + 1;
        end
        if (ev != 0 && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_raw = (m_raw & ~(a_en ? a_bits : '0)) | fires;
    m_b2  = m_b1;
    m_b1  = b;
  endfunction

  function automatic exp_t m_view(bit [NR_INT-1:0] msk);
    exp_t e;
    bit   found;
    e.raw    = m_raw;
    e.pend   = m_def;
    e.active = m_raw & ~msk;
    e.id     = '0;
    found    = 1'b0;
    for (int i = 0; i < NR_INT; i++) begin
      if (e.active[i] && !found) begin
        e.id  = ID_W'(i);
        found = 1'b1;
      end
    end
    e.vld = (e.active != '0);
    e.irq = (e.active != '0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, queue its expectation
  task automatic cycle(input bit b, input bit [NR_INT-1:0] ev_in,
                       input bit a_en, input bit [NR_INT-1:0] a_bits);
    busy   = b;
    intr   = ev_in;
    ack_en = a_en;
    ack    = a_bits;
    if (rst) m_reset();
    else     m_step(b, ev_in, a_en, a_bits, int'(thr), int'(tmo));
    exp_q.push_back(m_view(mask));
    @(negedge clk);
  endtask

  // Monitor: compare every post-edge output set with the queued expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("raw",    32'(raw),    32'(mon_e.raw));
      check("pend",   32'(pend),   32'(mon_e.pend));
      check("active", 32'(active), 32'(mon_e.active));
      check("id",     32'(id),     32'(mon_e.id));
      check("id_vld", 32'(id_vld), 32'(mon_e.vld));
      check("intr",   32'(irq),    32'(mon_e.irq));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_reset();
    rst = 1'b1; busy = 1'b0; intr = '0; mask = '0; ack_en = 1'b0; ack = '0;
    thr = 8'd4; tmo = '0;
    cycle(0, '0, 0, '0);
    cycle(0, '0, 0, '0);
    check("reset_raw",  32'(raw),  0);
    check("reset_intr", 32'(irq),  0);
    rst = 1'b0;

    // Threshold: four pulses on source 2
    repeat (4) cycle(0, 8'h04, 0, '0);
    check("thr_raw",  32'(raw), 32'h04);
    check("thr_intr", 32'(irq), 1);
    check("thr_id",   32'(id),  2);
    cycle(0, '0, 1, 8'h04);
    cycle(0, 8'h04, 0, '0);
    check("thr_cnt_cleared", 32'(raw), 0);

    // Timeout: one pulse on source 0 with tmo=5
    thr = 8'd10; tmo = 16'd5;
    cycle(0, 8'h01, 0, '0);
    repeat (4) cycle(0, '0, 0, '0);
    check("tmo_early", 32'(raw[0]), 0);
    cycle(0, '0, 0, '0);
    check("tmo_fire", 32'(raw[0]), 1);
    tmo = '0;
    cycle(0, '0, 1, 8'hFF);
    cycle(0, 8'h01, 0, '0);
    repeat (10) cycle(0, '0, 0, '0);
    check("tmo_off", 32'(raw[0]), 0);

    // Deferral while busy, flush on busy fall
    thr = 8'd1;
    cycle(0, '0, 1, 8'hFF);
    cycle(0, '0, 1, 8'hFF);
    cycle(1, '0, 0, '0);
    cycle(1, 8'h02, 0, '0);
    cycle(1, 8'h08, 0, '0);
    check("defer_pend", 32'(pend), 32'h0A);
    check("defer_raw",  32'(raw),  0);
    cycle(0, '0, 0, '0);
    check("flush_early", 32'(raw), 0);
    cycle(0, '0, 0, '0);
    check("flush_raw",  32'(raw),  32'h0A);
    check("flush_pend", 32'(pend), 0);

    // Ack versus fire on the same bit
    cycle(0, 8'h20, 1, 8'hFF);
    check("race_set", 32'(raw), 32'h20);
    cycle(0, 8'h20, 1, 8'h20);
    check("race_hold", 32'(raw), 32'h20);
    cycle(0, '0, 1, 8'h20);
    check("ack_clr",  32'(raw), 0);
    check("ack_intr", 32'(irq), 0);

    // Mask and priority
    mask = 8'h04;
    cycle(0, 8'h0C, 0, '0);
    check("mask_active", 32'(active), 32'h08);
    check("mask_id",     32'(id),     3);
    mask = 8'h0C;
    cycle(0, '0, 0, '0);
    check("mask_all_intr", 32'(irq), 0);
    check("mask_all_raw",  32'(raw), 32'h0C);

    // Reset while busy with deferred and accumulated events
    mask = '0; thr = 8'd4;
    cycle(0, '0, 1, 8'hFF);
    repeat (3) cycle(0, 8'h02, 0, '0);
    cycle(1, '0, 0, '0);
    cycle(1, 8'h01, 0, '0);
    check("pre_rst_pend", 32'(pend), 32'h01);
    rst = 1'b1;
    #1;
    check("async_rst_pend", 32'(pend), 0);
    check("async_rst_intr", 32'(irq),  0);
    cycle(1, '0, 0, '0);
    rst = 1'b0;
    cycle(0, 8'h02, 0, '0);
    repeat (3) cycle(0, '0, 0, '0);
    check("post_rst_raw",  32'(raw),  0);
    check("post_rst_pend", 32'(pend), 0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        thr = 8'($urandom_range(0, 5));
        tmo = 16'($urandom_range(0, 8));
      end
      if ($urandom_range(0, 3) == 0) mask = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      cycle(($urandom_range(0, 2) == 0) ? ~busy : busy,
            8'($urandom & $urandom & $urandom),
            ($urandom_range(0, 3) == 0), 8'($urandom));
    end
    rst = 1'b0;
    cycle(0, '0, 0, '0);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_vxe_intr_ctrl

`default_nettype wire
